// File: rtl/complex_gate_pipe_if.sv
// rtl/complex_gate_pipe_if.sv - input/output handshake bundle for complex_gate_pipe
interface complex_gate_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic [1:0]       out_mode;
    logic [CNT_W-1:0] out_cnt;

    // source of beats and sink of results
    modport master (
        output in_valid, in_mode, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_z, out_mode, out_cnt
    );

    // the pipeline itself
    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_z, out_mode, out_cnt
    );
endinterface

// File: rtl/complex_gate_pipe.sv
// rtl/complex_gate_pipe.sv - elastic pipelined 3-input bitwise gate; optional trace via COMPLEX_GATE_PIPE_TRACE_EN
module complex_gate_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input logic                clk,
    input logic                rst,
    complex_gate_pipe_if.slave bus
);
    logic [STAGES-1:0] vld;
    logic [1:0]        mode_q [STAGES];
    logic [WIDTH-1:0]  z_q    [STAGES];
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  func;
    logic [CNT_W-1:0]  cnt;
    logic              out_xfer;

    // bitwise function of the incoming beat; mode 0 is the legacy a/b/c gate
    always_comb begin
        func = '0;
        case (bus.in_mode)
            2'b00:   func = (bus.in_a & ~bus.in_c) ^ (bus.in_b & bus.in_c);
            2'b01:   func = (bus.in_a & bus.in_b) | bus.in_c;
            2'b10:   func = bus.in_a ^ bus.in_b ^ bus.in_c;
            default: func = (bus.in_a & bus.in_b) | (bus.in_a & bus.in_c) | (bus.in_b & bus.in_c);
        endcase
    end

    // stage k may load when it or any stage downstream of it is empty, or the sink takes a result;
    // written in unrolled form so no ready bit depends on another ready bit
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = bus.out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!vld[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    // pipeline registers: valid follows upstream on every ready cycle, payload only on a real beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                mode_q[k] <= '0;
                z_q[k]    <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    mode_q[0] <= bus.in_mode;
                    z_q[0]    <= func;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        mode_q[k] <= mode_q[k-1];
                        z_q[k]    <= z_q[k-1];
                    end
                end
            end
        end
    end

    assign out_xfer = vld[STAGES-1] & bus.out_ready;

    // delivered-result counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_xfer) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_mode  = mode_q[STAGES-1];
    assign bus.out_z     = z_q[STAGES-1];
    assign bus.out_cnt   = cnt;

`ifdef COMPLEX_GATE_PIPE_TRACE_EN
    // simulation trace of each delivered result; cnt shown before its increment
    always @(posedge clk) begin
        if (!rst && out_xfer) begin
            $display("t=%0t mode=%0d z=%b cnt=%0d", $time, bus.out_mode, bus.out_z, cnt);
        end
    end
`else
    // silent build: no trace logic
`endif
endmodule
